// File: rtl/fir_stream_ctrl_if.sv
// Signal bundle for fir_stream_ctrl: run control, sample-memory read port,
// FIR core hookup and the valid/ready result stream.
interface fir_stream_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int OUT_W  = 32,
  parameter int ADDR_W = 12
);
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              fir_clr;
  logic              fir_ce;
  logic [DATA_W-1:0] fir_x_in;
  logic [OUT_W-1:0]  fir_y_out;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;

  modport master (
    input  start, abort, len, rd_data, fir_y_out, out_ready,
    output busy, done, rd_en, rd_addr, fir_clr, fir_ce, fir_x_in,
           out_valid, out_data, out_last
  );

  modport slave (
    output start, abort, len, rd_data, fir_y_out, out_ready,
    input  busy, done, rd_en, rd_addr, fir_clr, fir_ce, fir_x_in,
           out_valid, out_data, out_last
  );
endinterface

// File: rtl/fir_stream_ctrl.sv
// Streams len samples from a synchronous-read memory through an external FIR core
// and forwards the results on a valid/ready stream with back-pressure stalling the FIR.
module fir_stream_ctrl #(
  parameter int DATA_W      = 12,
  parameter int OUT_W       = 32,
  parameter int ADDR_W      = 12,
  parameter int FIR_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  fir_stream_ctrl_if.master io_bus
);
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {StIdle, StPrime, StRun, StDrain, StFinish} state_e;

  state_e                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_fir_clr;
  logic                   r_out_last;
  logic [CNT_W-1:0]       r_len;
  logic [CNT_W-1:0]       r_issue_cnt;
  logic [CNT_W-1:0]       r_out_cnt;
  logic [ADDR_W-1:0]      r_rd_addr;
  // Issue-valid bits in flight through the FIR; the top bit is out_valid itself.
  logic [FIR_LATENCY-1:0] r_vpipe;

  logic                   w_active;
  logic                   w_fir_ce;
  logic                   w_issue;
  logic                   w_more;
  logic                   w_rd_run;
  logic                   w_vtail_in;
  logic                   w_abort_hit;
  logic [CNT_W-1:0]       w_next_idx;
  logic [FIR_LATENCY-1:0] w_vpipe_nxt;

  always_comb begin
    w_active    = (r_state == StRun) || (r_state == StDrain);
    w_fir_ce    = w_active && !(r_vpipe[FIR_LATENCY-1] && !io_bus.out_ready);
    w_issue     = (r_state == StRun) && w_fir_ce;
    w_next_idx  = r_issue_cnt + CNT_W'(1);
    w_more      = w_next_idx < r_len;
    w_rd_run    = w_issue && w_more;
    w_abort_hit = io_bus.abort &&
                  ((r_state == StPrime) || (r_state == StRun) || (r_state == StDrain));
    w_vpipe_nxt    = '0;
    w_vpipe_nxt[0] = w_issue;
    for (int i = 1; i < FIR_LATENCY; i++) begin
      w_vpipe_nxt[i] = r_vpipe[i-1];
    end
    w_vtail_in = w_vpipe_nxt[FIR_LATENCY-1];
  end

  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.fir_clr   = r_fir_clr;
  assign io_bus.fir_ce    = w_fir_ce;
  assign io_bus.rd_en     = (r_state == StPrime) || w_rd_run;
  assign io_bus.rd_addr   = w_rd_run ? w_next_idx[ADDR_W-1:0] : r_rd_addr;
  // Memory holds rd_data while rd_en is low, so a stalled RUN keeps fir_x_in steady.
  assign io_bus.fir_x_in  = (r_state == StRun) ? io_bus.rd_data : DATA_W'(0);
  assign io_bus.out_valid = r_vpipe[FIR_LATENCY-1];
  assign io_bus.out_last  = r_out_last;
  // The FIR is frozen whenever a result waits, so its output is the held result.
  assign io_bus.out_data  = r_vpipe[FIR_LATENCY-1] ? io_bus.fir_y_out : OUT_W'(0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fir_clr   <= 1'b0;
      r_out_last  <= 1'b0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_out_cnt   <= '0;
      r_rd_addr   <= '0;
      r_vpipe     <= '0;
    end else begin
      r_fir_clr <= 1'b0;
      r_done    <= 1'b0;
      if (w_fir_ce) begin
        r_vpipe <= w_vpipe_nxt;
        if (w_vtail_in) begin
          r_out_cnt  <= r_out_cnt + CNT_W'(1);
          r_out_last <= (r_out_cnt == r_len - CNT_W'(1));
        end else begin
          r_out_last <= 1'b0;
        end
      end
      if (w_issue) r_issue_cnt <= w_next_idx;
      if (w_rd_run) r_rd_addr <= w_next_idx[ADDR_W-1:0];

      if (w_abort_hit) begin
        r_state    <= StIdle;
        r_busy     <= 1'b0;
        r_fir_clr  <= 1'b1;
        r_vpipe    <= '0;
        r_out_last <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (io_bus.start) begin
              r_len       <= io_bus.len;
              r_issue_cnt <= '0;
              r_out_cnt   <= '0;
              r_rd_addr   <= '0;
              r_busy      <= 1'b1;
              if (io_bus.len != '0) begin
                r_state   <= StPrime;
                r_fir_clr <= 1'b1;
              end else begin
                r_state <= StFinish;
                r_done  <= 1'b1;
              end
            end
          end
          StPrime: r_state <= StRun;
          StRun: begin
            if (w_issue && !w_more) r_state <= StDrain;
          end
          StDrain: begin
            if (r_vpipe[FIR_LATENCY-1] && io_bus.out_ready && r_out_last) begin
              r_state <= StFinish;
              r_done  <= 1'b1;
            end
          end
          StFinish: begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_fir_clr <= io_bus.abort;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl: delay-line FIR stub, mem[i] = i-5, and a
// long randomly back-pressured run on a second instance with FIR_LATENCY=3.
module tb_fir_stream_ctrl;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_stream_ctrl_if #(.DATA_W(12), .OUT_W(32), .ADDR_W(AW)) bus_a ();
  fir_stream_ctrl_if #(.DATA_W(16), .OUT_W(32), .ADDR_W(AW)) bus_b ();

  fir_stream_ctrl #(.DATA_W(12), .OUT_W(32), .ADDR_W(AW), .FIR_LATENCY(1)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus_a)
  );

  fir_stream_ctrl #(.DATA_W(16), .OUT_W(32), .ADDR_W(AW), .FIR_LATENCY(3)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus_b)
  );

  // Sample memories and FIR stubs
  logic [31:0] dl_a;
  logic [31:0] dl_b [3];

  always @(posedge clk or posedge rst)
    if (rst) bus_a.rd_data <= '0;
    else if (bus_a.rd_en) bus_a.rd_data <= 12'(int'(bus_a.rd_addr) - 5);

  always @(posedge clk or posedge rst)
    if (rst) bus_b.rd_data <= '0;
    else if (bus_b.rd_en) bus_b.rd_data <= 16'(int'(bus_b.rd_addr) - 5);

  always @(posedge clk or posedge rst)
    if (rst) dl_a <= '0;
    else if (bus_a.fir_clr) dl_a <= '0;
    else if (bus_a.fir_ce) dl_a <= {{20{bus_a.fir_x_in[11]}}, bus_a.fir_x_in};
  assign bus_a.fir_y_out = dl_a;

  always @(posedge clk or posedge rst)
    if (rst) begin
      dl_b[0] <= '0; dl_b[1] <= '0; dl_b[2] <= '0;
    end else if (bus_b.fir_clr) begin
      dl_b[0] <= '0; dl_b[1] <= '0; dl_b[2] <= '0;
    end else if (bus_b.fir_ce) begin
      dl_b[0] <= {{16{bus_b.fir_x_in[15]}}, bus_b.fir_x_in};
      dl_b[1] <= dl_b[0];
      dl_b[2] <= dl_b[1];
    end
  assign bus_b.fir_y_out = dl_b[2];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input int d, input logic l);
    chk({tag, ".valid"}, bus_a.out_valid, 1);
    chk({tag, ".data"}, $signed(bus_a.out_data), d);
    chk({tag, ".last"}, bus_a.out_last, l);
  endtask

  int   n_got, bad_data, bad_last, bad_hold, max_addr;
  logic done_seen, seen_a;
  logic prev_stall;
  logic [31:0] prev_data;

  initial begin
    bus_a.start = 0; bus_a.abort = 0; bus_a.len = '0; bus_a.out_ready = 1;
    bus_b.start = 0; bus_b.abort = 0; bus_b.len = '0; bus_b.out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    mid();
    chk("reset.busy", bus_a.busy, 0);
    chk("reset.out_valid", bus_a.out_valid, 0);

    // len=4, out_ready high
    tick(); bus_a.start = 1; bus_a.len = 4; mid();
    chk("t1.c0.busy", bus_a.busy, 0);
    tick(); bus_a.start = 0; mid();
    chk("t1.c1.busy", bus_a.busy, 1);
    chk("t1.c1.fir_clr", bus_a.fir_clr, 1);
    chk("t1.c1.rd_en", bus_a.rd_en, 1);
    chk("t1.c1.rd_addr", bus_a.rd_addr, 0);
    chk("t1.c1.fir_ce", bus_a.fir_ce, 0);
    tick(); mid();
    chk("t1.c2.fir_x_in", $signed(bus_a.fir_x_in), -5);
    chk("t1.c2.fir_ce", bus_a.fir_ce, 1);
    chk("t1.c2.rd_addr", bus_a.rd_addr, 1);
    chk("t1.c2.out_valid", bus_a.out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick(); mid();
      chk_out($sformatf("t1.c%0d", k + 3), k - 5, k == 3);
    end
    tick(); mid();
    chk("t1.c7.done", bus_a.done, 1);
    chk("t1.c7.out_valid", bus_a.out_valid, 0);
    tick(); mid();
    chk("t1.c8.busy", bus_a.busy, 0);
    chk("t1.c8.done", bus_a.done, 0);

    // len=4, out_ready low for cycles 4..6
    tick(); bus_a.start = 1; bus_a.len = 4; mid();
    tick(); bus_a.start = 0; mid();
    tick(); mid();
    tick(); mid();
    chk_out("t2.c3", -5, 0);
    tick(); bus_a.out_ready = 0; mid();
    chk("t2.c4.fir_ce", bus_a.fir_ce, 0);
    chk_out("t2.c4", -4, 0);
    tick(); mid();
    chk("t2.c5.fir_ce", bus_a.fir_ce, 0);
    chk("t2.c5.rd_en", bus_a.rd_en, 0);
    chk_out("t2.c5", -4, 0);
    tick(); mid();
    chk("t2.c6.fir_ce", bus_a.fir_ce, 0);
    chk_out("t2.c6", -4, 0);
    tick(); bus_a.out_ready = 1; mid();
    chk("t2.c7.fir_ce", bus_a.fir_ce, 1);
    chk_out("t2.c7", -4, 0);
    tick(); mid();
    chk_out("t2.c8", -3, 0);
    tick(); mid();
    chk_out("t2.c9", -2, 1);
    tick(); mid();
    chk("t2.c10.done", bus_a.done, 1);
    tick(); mid();
    chk("t2.c11.busy", bus_a.busy, 0);

    // len=0, with abort landing in FINISH
    tick(); bus_a.start = 1; bus_a.len = 0; mid();
    chk("t3.c0.rd_en", bus_a.rd_en, 0);
    tick(); bus_a.start = 0; bus_a.abort = 1; mid();
    chk("t3.c1.done", bus_a.done, 1);
    chk("t3.c1.rd_en", bus_a.rd_en, 0);
    chk("t3.c1.out_valid", bus_a.out_valid, 0);
    tick(); bus_a.abort = 0; mid();
    chk("t3.c2.busy", bus_a.busy, 0);
    chk("t3.c2.done", bus_a.done, 0);

    // len=10 aborted at cycle 5
    tick(); bus_a.start = 1; bus_a.len = 10; mid();
    tick(); bus_a.start = 0; mid();
    tick(); mid();
    tick(); mid();
    chk_out("t4.c3", -5, 0);
    tick(); mid();
    tick(); bus_a.abort = 1; mid();
    chk("t4.c5.busy", bus_a.busy, 1);
    tick(); bus_a.abort = 0; mid();
    chk("t4.c6.busy", bus_a.busy, 0);
    chk("t4.c6.out_valid", bus_a.out_valid, 0);
    chk("t4.c6.out_last", bus_a.out_last, 0);
    chk("t4.c6.fir_clr", bus_a.fir_clr, 1);
    chk("t4.c6.done", bus_a.done, 0);
    tick(); mid();
    chk("t4.c7.fir_clr", bus_a.fir_clr, 0);
    chk("t4.c7.done", bus_a.done, 0);
    tick(); bus_a.abort = 1; mid();
    tick(); bus_a.abort = 0; mid();
    chk("t4.idle_abort.fir_clr", bus_a.fir_clr, 0);
    chk("t4.idle_abort.busy", bus_a.busy, 0);
    // start and abort together in IDLE: start wins
    tick(); bus_a.start = 1; bus_a.abort = 1; bus_a.len = 2; mid();
    tick(); bus_a.start = 0; bus_a.abort = 0; mid();
    chk("t4b.c1.busy", bus_a.busy, 1);
    chk("t4b.c1.fir_clr", bus_a.fir_clr, 1);
    tick(); mid();
    tick(); mid();
    chk_out("t4b.c3", -5, 0);
    tick(); mid();
    chk_out("t4b.c4", -4, 1);
    tick(); mid();
    chk("t4b.c5.done", bus_a.done, 1);

    // Reset pulse in cycle 4 of a len=8 run
    tick(); bus_a.start = 1; bus_a.len = 8; mid();
    tick(); bus_a.start = 0; mid();
    tick(); mid();
    tick(); mid();
    tick(); rst = 1; mid();
    chk("t5.rst.busy", bus_a.busy, 0);
    chk("t5.rst.done", bus_a.done, 0);
    chk("t5.rst.rd_en", bus_a.rd_en, 0);
    chk("t5.rst.rd_addr", bus_a.rd_addr, 0);
    chk("t5.rst.fir_clr", bus_a.fir_clr, 0);
    chk("t5.rst.fir_ce", bus_a.fir_ce, 0);
    chk("t5.rst.fir_x_in", bus_a.fir_x_in, 0);
    chk("t5.rst.out_valid", bus_a.out_valid, 0);
    chk("t5.rst.out_data", bus_a.out_data, 0);
    chk("t5.rst.out_last", bus_a.out_last, 0);
    tick(); rst = 0; mid();
    seen_a = 0;
    for (int c = 0; c < 12; c++) begin
      tick(); mid();
      if (bus_a.done || bus_a.out_valid || bus_a.busy) seen_a = 1;
    end
    chk("t5.post_rst_quiet", seen_a, 0);
    tick(); bus_a.start = 1; bus_a.len = 3; mid();
    tick(); bus_a.start = 0; mid();
    tick(); mid();
    for (int k = 0; k < 3; k++) begin
      tick(); mid();
      chk_out($sformatf("t5b.c%0d", k + 3), k - 5, k == 2);
    end
    tick(); mid();
    chk("t5b.c6.done", bus_a.done, 1);

    // len=4000, FIR_LATENCY=3, random out_ready
    n_got = 0; bad_data = 0; bad_last = 0; bad_hold = 0; max_addr = 0;
    done_seen = 0; prev_stall = 0; prev_data = '0;
    tick(); bus_b.start = 1; bus_b.len = 4000; mid();
    tick(); bus_b.start = 0; mid();
    for (int c = 0; c < 30000 && !done_seen; c++) begin
      tick(); bus_b.out_ready = ($urandom_range(0, 3) != 0); mid();
      if (bus_b.rd_en && int'(bus_b.rd_addr) > max_addr) max_addr = int'(bus_b.rd_addr);
      if (prev_stall && (!bus_b.out_valid || bus_b.out_data !== prev_data)) bad_hold++;
      if (bus_b.out_valid && bus_b.out_ready) begin
        if ($signed(bus_b.out_data) != n_got - 5) bad_data++;
        if (bus_b.out_last !== (n_got == 3999)) bad_last++;
        n_got++;
      end
      prev_stall = bus_b.out_valid && !bus_b.out_ready;
      prev_data  = bus_b.out_data;
      if (bus_b.done) done_seen = 1;
    end
    chk("t6.result_count", n_got, 4000);
    chk("t6.bad_data", bad_data, 0);
    chk("t6.bad_last", bad_last, 0);
    chk("t6.bad_hold", bad_hold, 0);
    chk("t6.max_rd_addr", max_addr, 3999);
    chk("t6.done_seen", done_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
